// File: rtl/luma_stats_pkg.sv
// luma_stats_pkg: shared data-type tags and state encoding for the luma statistics stage
package luma_stats_pkg;

   localparam int DTYPE_WIDTH = 4;

   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_LINE_START  = 4'h3;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_IMAGE       = 4'h8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } state_t;

   // Every tag with the top bit set carries image samples
   function automatic logic dtype_is_image(input logic [DTYPE_WIDTH-1:0] d);
      return d[DTYPE_WIDTH-1];
   endfunction

endpackage

// File: rtl/luma_stats_sat_accum.sv
// luma_stats_sat_accum: saturating accumulator register with synchronous clear
module luma_stats_sat_accum #(
   parameter int W = 32
) (
   input  logic         pixclk,
   input  logic         resetb,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] inc,
   output logic [W-1:0] q
);

   logic [W:0] s;

   assign s = {1'b0, q} + {1'b0, inc};

   // Sticks at all-ones once the sum carries out instead of wrapping
   always_ff @(posedge pixclk or posedge resetb)
      if (resetb)   q <= '0;
      else if (clr) q <= '0;
      else if (en)  q <= s[W] ? '1 : s[W-1:0];

endmodule

// File: rtl/luma_stats.sv
// luma_stats: pixel pass-through with per-frame luma sum/count/min/max/clip statistics
module luma_stats
   import luma_stats_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int SUM_WIDTH   = 32,
   parameter int CNT_WIDTH   = 24
) (
   input  logic                          pixclk,
   input  logic                          resetb,
   input  logic                          enable,
   input  logic [PIXEL_WIDTH-1:0]        clip_thresh,
   input  logic                          dvi,
   input  logic [DTYPE_WIDTH-1:0]        dtypei,
   input  logic [PIXEL_WIDTH-1:0]        y,
   input  logic signed [PIXEL_WIDTH-1:0] u,
   input  logic signed [PIXEL_WIDTH-1:0] v,
   input  logic [15:0]                   meta_datai,
   output logic                          dvo,
   output logic [DTYPE_WIDTH-1:0]        dtypeo,
   output logic [PIXEL_WIDTH-1:0]        yo,
   output logic signed [PIXEL_WIDTH-1:0] uo,
   output logic signed [PIXEL_WIDTH-1:0] vo,
   output logic [15:0]                   meta_datao,
   output logic [SUM_WIDTH-1:0]          stat_sum,
   output logic [CNT_WIDTH-1:0]          stat_count,
   output logic [PIXEL_WIDTH-1:0]        stat_min,
   output logic [PIXEL_WIDTH-1:0]        stat_max,
   output logic [CNT_WIDTH-1:0]          stat_clip,
   output logic [15:0]                   stat_frame,
   output logic                          stat_valid
);

   state_t state, state_nxt;

   logic fs, fe, pix, clr, acc, rpt;
   logic [SUM_WIDTH-1:0]   sum;
   logic [CNT_WIDTH-1:0]   cnt, clip;
   logic [PIXEL_WIDTH-1:0] run_min, run_max;

   assign fs  = dvi && dtypei == DTYPE_FRAME_START;
   assign fe  = dvi && dtypei == DTYPE_FRAME_END;
   assign pix = dvi && dtype_is_image(dtypei);
   assign clr = fs && enable;
   assign acc = state == ACCUM && pix;
   assign rpt = state == ACCUM && fe;

   // State register
   always_ff @(posedge pixclk or posedge resetb)
      if (resetb) state <= IDLE;
      else        state <= state_nxt;

   // Any frame start re-samples enable; a frame end only matters while accumulating
   always_comb begin
      state_nxt  = state;
      stat_valid = 1'b0;
      state_nxt  = fs ? (enable ? ACCUM : IDLE) :
                   rpt ? REPORT :
                   state == REPORT ? IDLE : state;
      stat_valid = state == REPORT;
   end

   luma_stats_sat_accum #(.W(SUM_WIDTH)) u_sum (
      .pixclk(pixclk), .resetb(resetb), .clr(clr), .en(acc),
      .inc(SUM_WIDTH'(y)), .q(sum)
   );

   luma_stats_sat_accum #(.W(CNT_WIDTH)) u_cnt (
      .pixclk(pixclk), .resetb(resetb), .clr(clr), .en(acc),
      .inc(CNT_WIDTH'(1)), .q(cnt)
   );

   luma_stats_sat_accum #(.W(CNT_WIDTH)) u_clip (
      .pixclk(pixclk), .resetb(resetb), .clr(clr), .en(acc),
      .inc(CNT_WIDTH'(y >= clip_thresh)), .q(clip)
   );

   // Running min/max start from the opposite extremes so an empty frame reports them as-is
   always_ff @(posedge pixclk or posedge resetb)
      if (resetb || clr) begin
         run_min <= '1;
         run_max <= '0;
      end else if (acc) begin
         run_min <= y < run_min ? y : run_min;
         run_max <= y > run_max ? y : run_max;
      end

   // Results land on the edge entering REPORT so they are stable while stat_valid is high
   always_ff @(posedge pixclk or posedge resetb)
      if (resetb) begin
         stat_sum   <= '0;
         stat_count <= '0;
         stat_min   <= '0;
         stat_max   <= '0;
         stat_clip  <= '0;
         stat_frame <= '0;
      end else if (rpt) begin
         stat_sum   <= sum;
         stat_count <= cnt;
         stat_min   <= run_min;
         stat_max   <= run_max;
         stat_clip  <= clip;
         stat_frame <= stat_frame + 16'd1;
      end

   // One-cycle registered pass-through of the pixel stream
   always_ff @(posedge pixclk or posedge resetb)
      if (resetb) begin
         dvo        <= 1'b0;
         dtypeo     <= '0;
         yo         <= '0;
         uo         <= '0;
         vo         <= '0;
         meta_datao <= '0;
      end else begin
         dvo        <= dvi;
         dtypeo     <= dtypei;
         yo         <= y;
         uo         <= u;
         vo         <= v;
         meta_datao <= meta_datai;
      end

endmodule

// File: tb/tb_luma_stats.sv
// tb_luma_stats: randomized and directed checks of luma_stats against a frame-level reference model
module tb_luma_stats;
   import luma_stats_pkg::*;

   localparam int PW = 8;

   logic                   pixclk = 1'b0;
   logic                   resetb = 1'b1;
   logic                   enable = 1'b0;
   logic [PW-1:0]          clip_thresh = '0;
   logic                   dvi = 1'b0;
   logic [DTYPE_WIDTH-1:0] dtypei = '0;
   logic [PW-1:0]          y = '0;
   logic signed [PW-1:0]   u = '0;
   logic signed [PW-1:0]   v = '0;
   logic [15:0]            meta_datai = '0;

   logic                   dvo, stat_valid;
   logic [DTYPE_WIDTH-1:0] dtypeo;
   logic [PW-1:0]          yo, stat_min, stat_max;
   logic signed [PW-1:0]   uo, vo;
   logic [15:0]            meta_datao, stat_frame;
   logic [31:0]            stat_sum;
   logic [23:0]            stat_count, stat_clip;

   logic                   b_dvo, b_stat_valid;
   logic [DTYPE_WIDTH-1:0] b_dtypeo;
   logic [PW-1:0]          b_yo, b_stat_min, b_stat_max;
   logic signed [PW-1:0]   b_uo, b_vo;
   logic [15:0]            b_meta_datao, b_stat_frame;
   logic [9:0]             b_stat_sum;
   logic [2:0]             b_stat_count, b_stat_clip;

   int checks = 0;
   int errors = 0;

   luma_stats dut (
      .pixclk(pixclk), .resetb(resetb), .enable(enable), .clip_thresh(clip_thresh),
      .dvi(dvi), .dtypei(dtypei), .y(y), .u(u), .v(v), .meta_datai(meta_datai),
      .dvo(dvo), .dtypeo(dtypeo), .yo(yo), .uo(uo), .vo(vo), .meta_datao(meta_datao),
      .stat_sum(stat_sum), .stat_count(stat_count), .stat_min(stat_min), .stat_max(stat_max),
      .stat_clip(stat_clip), .stat_frame(stat_frame), .stat_valid(stat_valid)
   );

   luma_stats #(.SUM_WIDTH(10), .CNT_WIDTH(3)) dut_narrow (
      .pixclk(pixclk), .resetb(resetb), .enable(enable), .clip_thresh(clip_thresh),
      .dvi(dvi), .dtypei(dtypei), .y(y), .u(u), .v(v), .meta_datai(meta_datai),
      .dvo(b_dvo), .dtypeo(b_dtypeo), .yo(b_yo), .uo(b_uo), .vo(b_vo), .meta_datao(b_meta_datao),
      .stat_sum(b_stat_sum), .stat_count(b_stat_count), .stat_min(b_stat_min), .stat_max(b_stat_max),
      .stat_clip(b_stat_clip), .stat_frame(b_stat_frame), .stat_valid(b_stat_valid)
   );

   always #5 pixclk = ~pixclk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic longint sat(input longint x, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return x > m ? m : x;
   endfunction

   // Reference model: a frame is the list of luma values seen between an enabled start and its end
   logic                   e_dv, e_valid;
   logic [DTYPE_WIDTH-1:0] e_dt;
   logic [PW-1:0]          e_y, e_min, e_max;
   logic signed [PW-1:0]   e_u, e_v;
   logic [15:0]            e_md, e_frame;
   longint                 e_sum0, e_sum1, e_cnt0, e_cnt1, e_clip0, e_clip1;
   bit                     in_frame;
   int                     ys[$];
   int                     nclip;

   task automatic model_report();
      longint s;
      int mn, mx;
      s = 0;
      mn = 255;
      mx = 0;
      foreach (ys[i]) begin
         s += ys[i];
         if (ys[i] < mn) mn = ys[i];
         if (ys[i] > mx) mx = ys[i];
      end
      e_sum0  = sat(s, 32);
      e_sum1  = sat(s, 10);
      e_cnt0  = sat(ys.size(), 24);
      e_cnt1  = sat(ys.size(), 3);
      e_clip0 = sat(nclip, 24);
      e_clip1 = sat(nclip, 3);
      e_min   = PW'(mn);
      e_max   = PW'(mx);
      e_frame = e_frame + 16'd1;
      e_valid = 1'b1;
      in_frame = 1'b0;
   endtask

   always @(posedge pixclk or posedge resetb) begin
      if (resetb) begin
         e_dv = 0; e_dt = '0; e_y = '0; e_u = '0; e_v = '0; e_md = '0;
         e_sum0 = 0; e_sum1 = 0; e_cnt0 = 0; e_cnt1 = 0; e_clip0 = 0; e_clip1 = 0;
         e_min = '0; e_max = '0; e_frame = '0; e_valid = 0;
         in_frame = 0; ys.delete(); nclip = 0;
      end else begin
         e_dv = dvi; e_dt = dtypei; e_y = y; e_u = u; e_v = v; e_md = meta_datai;
         e_valid = 0;
         if (dvi && dtypei == DTYPE_FRAME_START) begin
            in_frame = enable;
            ys.delete();
            nclip = 0;
         end else if (dvi && dtypei == DTYPE_FRAME_END && in_frame) begin
            model_report();
         end else if (dvi && dtype_is_image(dtypei) && in_frame) begin
            ys.push_back(int'(y));
            if (y >= clip_thresh) nclip++;
         end
      end
   end

   // Every-cycle comparison of both instances against the model
   always @(negedge pixclk) begin
      chk("dvo", dvo, e_dv);
      chk("dtypeo", dtypeo, e_dt);
      chk("yo", yo, e_y);
      chk("uo", uo, e_u);
      chk("vo", vo, e_v);
      chk("meta_datao", meta_datao, e_md);
      chk("stat_valid", stat_valid, e_valid);
      chk("stat_sum", stat_sum, e_sum0);
      chk("stat_count", stat_count, e_cnt0);
      chk("stat_clip", stat_clip, e_clip0);
      chk("stat_min", stat_min, e_min);
      chk("stat_max", stat_max, e_max);
      chk("stat_frame", stat_frame, e_frame);
      chk("n_yo", b_yo, e_y);
      chk("n_dvo", b_dvo, e_dv);
      chk("n_dtypeo", b_dtypeo, e_dt);
      chk("n_uo", b_uo, e_u);
      chk("n_vo", b_vo, e_v);
      chk("n_meta_datao", b_meta_datao, e_md);
      chk("n_stat_valid", b_stat_valid, e_valid);
      chk("n_stat_sum", b_stat_sum, e_sum1);
      chk("n_stat_count", b_stat_count, e_cnt1);
      chk("n_stat_clip", b_stat_clip, e_clip1);
      chk("n_stat_min", b_stat_min, e_min);
      chk("n_stat_max", b_stat_max, e_max);
      chk("n_stat_frame", b_stat_frame, e_frame);
   end

   task automatic drive(input logic d, input logic [DTYPE_WIDTH-1:0] t, input logic [PW-1:0] yy);
      dvi = d;
      dtypei = t;
      y = yy;
      u = PW'($urandom);
      v = PW'($urandom);
      meta_datai = 16'($urandom);
      @(posedge pixclk);
      #2;
   endtask

   task automatic fstart();
      drive(1'b1, DTYPE_FRAME_START, '0);
   endtask

   task automatic fend();
      drive(1'b1, DTYPE_FRAME_END, '0);
   endtask

   task automatic px(input logic [PW-1:0] yy);
      drive(1'b1, DTYPE_IMAGE, yy);
   endtask

   task automatic rand_cycle();
      int r;
      logic [DTYPE_WIDTH-1:0] t;
      r = $urandom_range(99);
      t = r < 40 ? DTYPE_WIDTH'(8 + $urandom_range(7)) :
          r < 46 ? DTYPE_FRAME_START :
          r < 52 ? DTYPE_FRAME_END :
          r < 70 ? DTYPE_WIDTH'($urandom_range(7, 3)) : DTYPE_WIDTH'($urandom);
      clip_thresh = $urandom_range(9) == 0 ? '0 : PW'($urandom);
      drive($urandom_range(9) != 0, t, PW'($urandom));
   endtask

   initial begin
      @(posedge pixclk);
      #2;
      chk("rst stat_valid", stat_valid, 0);
      chk("rst stat_min", stat_min, 0);
      chk("rst stat_max", stat_max, 0);
      chk("rst stat_frame", stat_frame, 0);
      chk("rst dvo", dvo, 0);
      resetb = 1'b0;

      enable = 1'b0;
      repeat (200) rand_cycle();

      enable = 1'b1;
      clip_thresh = 8'd200;
      fstart();
      px(8'd10); px(8'd250); px(8'd100); px(8'd200);
      fend();
      chk("basic valid", stat_valid, 1);
      chk("basic sum", stat_sum, 560);
      chk("basic count", stat_count, 4);
      chk("basic min", stat_min, 10);
      chk("basic max", stat_max, 250);
      chk("basic clip", stat_clip, 2);
      chk("basic frame", stat_frame, 1);
      drive(1'b0, '0, '0);
      chk("basic pulse end", stat_valid, 0);
      chk("basic hold", stat_sum, 560);

      fstart();
      fend();
      chk("empty valid", stat_valid, 1);
      chk("empty count", stat_count, 0);
      chk("empty sum", stat_sum, 0);
      chk("empty clip", stat_clip, 0);
      chk("empty min", stat_min, 8'hff);
      chk("empty max", stat_max, 0);
      chk("empty frame", stat_frame, 2);

      fstart();
      repeat (3) px(8'd50);
      fstart();
      chk("restart no valid", stat_valid, 0);
      repeat (2) px(8'd7);
      fend();
      chk("restart count", stat_count, 2);
      chk("restart sum", stat_sum, 14);
      chk("restart min", stat_min, 7);
      chk("restart max", stat_max, 7);
      chk("restart frame", stat_frame, 3);

      fstart();
      repeat (8) px(8'd255);
      fend();
      chk("sat narrow sum", b_stat_sum, 10'h3ff);
      chk("sat count", stat_count, 8);
      chk("sat wide sum", stat_sum, 2040);
      chk("sat narrow count", b_stat_count, 7);
      chk("sat narrow clip", b_stat_clip, 7);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(19) == 0) enable = ~enable;
         rand_cycle();
      end

      enable = 1'b1;
      clip_thresh = 8'd0;
      fstart();
      px(8'd30);
      px(8'd40);
      resetb = 1'b1;
      #1;
      chk("rst mid valid", stat_valid, 0);
      chk("rst mid sum", stat_sum, 0);
      chk("rst mid count", stat_count, 0);
      chk("rst mid frame", stat_frame, 0);
      chk("rst mid yo", yo, 0);
      chk("rst mid dvo", dvo, 0);
      @(posedge pixclk);
      #2;
      resetb = 1'b0;
      fend();
      chk("rst end no valid", stat_valid, 0);
      chk("rst end frame", stat_frame, 0);
      drive(1'b0, '0, '0);
      drive(1'b0, '0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
